// File: rtl/frame_buffer_scheduler_if.sv
// SDRAM controller burst interface: command/address out, per-beat handshakes back.
interface frame_buffer_scheduler_if;
  logic [1:0]  command;
  logic [21:0] data_address;
  logic        data_read_valid;
  logic        data_write_done;

  modport master (
    output command,
    output data_address,
    input  data_read_valid,
    input  data_write_done
  );

  modport slave (
    input  command,
    input  data_address,
    output data_read_valid,
    output data_write_done
  );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffered frame scheduler: arbitrates camera write bursts and display read
// bursts to the SDRAM controller and rotates the three frame buffers.
//
// state    | meaning
// ST_IDLE  | command=0; apply pending frame_start/vsync, pick the next burst
// ST_WRITE | command=1; one write burst from the camera FIFO
// ST_READ  | command=2; one read burst into the display FIFO
module frame_buffer_scheduler #(
  parameter int          VIDEO_END        = 153600,
  parameter int          BURST_LENGTH     = 8,
  parameter logic [21:0] BUFFER_STRIDE    = 22'h080000,
  parameter int          LEVEL_WIDTH      = 8,
  parameter int          READ_FIFO_DEPTH  = 255,
  parameter int          MAX_WRITE_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LEVEL_WIDTH-1:0] write_level,
  output logic                   write_pop,
  input  logic [LEVEL_WIDTH-1:0] read_used,
  output logic                   read_push,
  input  logic                   frame_start,
  input  logic                   display_vsync,
  frame_buffer_scheduler_if.master sdram,
  output logic [1:0]             read_buffer,
  output logic                   frame_dropped
);

  localparam int AW       = 22;
  localparam int LW1      = LEVEL_WIDTH + 1;
  localparam int BEAT_W   = $clog2(BURST_LENGTH + 1);
  localparam int STREAK_W = $clog2(MAX_WRITE_STREAK + 1);

  localparam logic [AW-1:0]          OFF_BURST  = AW'(BURST_LENGTH);
  localparam logic [AW-1:0]          OFF_END    = AW'(VIDEO_END);
  localparam logic [LEVEL_WIDTH-1:0] LVL_BURST  = LEVEL_WIDTH'(BURST_LENGTH);
  localparam logic [LW1-1:0]         RD_BURST   = LW1'(BURST_LENGTH);
  localparam logic [LW1-1:0]         RD_DEPTH   = LW1'(READ_FIFO_DEPTH);
  localparam logic [BEAT_W-1:0]      BEAT_LOAD  = BEAT_W'(BURST_LENGTH - 1);
  localparam logic [STREAK_W-1:0]    STREAK_MAX = STREAK_W'(MAX_WRITE_STREAK);
  localparam logic [AW-1:0]          BASE_1     = BUFFER_STRIDE;
  localparam logic [AW-1:0]          BASE_2     = BUFFER_STRIDE + BUFFER_STRIDE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t              state;
  logic [AW-1:0]       addr_q;
  logic [AW-1:0]       write_offset;
  logic [AW-1:0]       read_offset;
  logic [1:0]          write_buf;
  logic [1:0]          read_buf;
  logic [1:0]          latest;
  logic                latest_valid;
  logic [STREAK_W-1:0] streak;
  logic [BEAT_W-1:0]   beats_left;
  logic                fs_pend;
  logic                vs_pend;

  logic          fs_eff;
  logic          vs_eff;
  logic [AW-1:0] wr_off_adj;
  logic [AW-1:0] rd_off_adj;
  logic [1:0]    rd_buf_adj;
  logic          drop_now;
  logic          wr_elig;
  logic          rd_elig;
  logic          grant_read;
  logic          grant_write;
  logic [AW-1:0] wr_off_next;
  logic [AW-1:0] rd_off_next;

  function automatic logic [AW-1:0] buf_base(input logic [1:0] idx);
    case (idx)
      2'd1:    return BASE_1;
      2'd2:    return BASE_2;
      default: return '0;
    endcase
  endfunction

  // Values as they stand after the IDLE cycle applies any pending frame events,
  // so a burst granted in the same cycle already uses the new buffer/offset.
  always_comb begin
    fs_eff      = fs_pend | frame_start;
    vs_eff      = vs_pend | display_vsync;
    wr_off_adj  = write_offset;
    drop_now    = 1'b0;
    if (fs_eff && (write_offset != '0)) begin
      wr_off_adj = '0;
      drop_now   = 1'b1;
    end
    rd_off_adj  = vs_eff ? '0 : read_offset;
    rd_buf_adj  = (vs_eff && latest_valid) ? latest : read_buf;
    wr_elig     = (write_level >= LVL_BURST);
    rd_elig     = latest_valid && (({1'b0, read_used} + RD_BURST) <= RD_DEPTH);
    grant_read  = rd_elig && (!wr_elig || (streak >= STREAK_MAX));
    grant_write = wr_elig && !grant_read;
    wr_off_next = write_offset + OFF_BURST;
    rd_off_next = read_offset + OFF_BURST;
  end

  assign sdram.command      = state;
  assign sdram.data_address = addr_q;
  assign write_pop          = (state == ST_WRITE) && sdram.data_write_done;
  assign read_push          = (state == ST_READ) && sdram.data_read_valid;
  assign read_buffer        = read_buf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      write_offset  <= '0;
      read_offset   <= '0;
      write_buf     <= 2'd0;
      read_buf      <= 2'd1;
      latest        <= 2'd0;
      latest_valid  <= 1'b0;
      streak        <= '0;
      beats_left    <= '0;
      fs_pend       <= 1'b0;
      vs_pend       <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      frame_dropped <= 1'b0;
      fs_pend       <= (state == ST_IDLE) ? 1'b0 : (fs_pend | frame_start);
      vs_pend       <= (state == ST_IDLE) ? 1'b0 : (vs_pend | display_vsync);
      case (state)
        ST_IDLE: begin
          write_offset  <= wr_off_adj;
          read_offset   <= rd_off_adj;
          read_buf      <= rd_buf_adj;
          frame_dropped <= drop_now;
          beats_left    <= BEAT_LOAD;
          if (grant_read) begin
            state  <= ST_READ;
            streak <= '0;
            addr_q <= buf_base(rd_buf_adj) + rd_off_adj;
          end else if (grant_write) begin
            state  <= ST_WRITE;
            if (streak != STREAK_MAX) streak <= streak + 1'b1;
            addr_q <= buf_base(write_buf) + wr_off_adj;
          end else begin
            addr_q <= '0;
          end
        end
        ST_WRITE: begin
          if (sdram.data_write_done) begin
            if (beats_left == '0) begin
              state  <= ST_IDLE;
              addr_q <= '0;
              if (wr_off_next == OFF_END) begin
                // Finished frame becomes newest; write moves to the one buffer
                // that is neither being displayed nor the newest.
                write_offset <= '0;
                latest       <= write_buf;
                latest_valid <= 1'b1;
                write_buf    <= 2'd3 - read_buf - write_buf;
              end else begin
                write_offset <= wr_off_next;
              end
            end else begin
              beats_left <= beats_left - 1'b1;
            end
          end
        end
        ST_READ: begin
          if (sdram.data_read_valid) begin
            if (beats_left == '0) begin
              state       <= ST_IDLE;
              addr_q      <= '0;
              read_offset <= (rd_off_next == OFF_END) ? '0 : rd_off_next;
            end else begin
              beats_left <= beats_left - 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          addr_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Scenario bench for frame_buffer_scheduler: expected bursts are queued per scenario
// and checked as the scheduler issues them.
module tb_frame_buffer_scheduler;
  localparam int          BL     = 8;
  localparam int          VE     = 16;
  localparam int          LW     = 8;
  localparam logic [21:0] STRIDE = 22'h080000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [LW-1:0] write_level;
  logic [LW-1:0] read_used;
  logic          write_pop;
  logic          read_push;
  logic          frame_start;
  logic          display_vsync;
  logic [1:0]    read_buffer;
  logic          frame_dropped;

  frame_buffer_scheduler_if sdram_bus ();

  frame_buffer_scheduler #(
    .VIDEO_END        (VE),
    .BURST_LENGTH     (BL),
    .BUFFER_STRIDE    (STRIDE),
    .LEVEL_WIDTH      (LW),
    .READ_FIFO_DEPTH  (255),
    .MAX_WRITE_STREAK (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_level   (write_level),
    .write_pop     (write_pop),
    .read_used     (read_used),
    .read_push     (read_push),
    .frame_start   (frame_start),
    .display_vsync (display_vsync),
    .sdram         (sdram_bus),
    .read_buffer   (read_buffer),
    .frame_dropped (frame_dropped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];

  task automatic push_exp(input logic [1:0] cmd, input logic [21:0] addr);
    exp_q.push_back({cmd, addr});
  endtask

  task automatic do_reset();
    reset_n                   = 1'b0;
    write_level               = '0;
    read_used                 = '0;
    frame_start               = 1'b0;
    display_vsync             = 1'b0;
    sdram_bus.data_read_valid = 1'b0;
    sdram_bus.data_write_done = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for the next burst, checks it against the queue head, serves its beats with
  // random stalls, then checks the burst closes into IDLE.
  task automatic run_burst(input int vs_beat, output int waited);
    logic [23:0] e;
    logic [1:0]  ecmd;
    logic [21:0] eaddr;
    logic        is_wr;
    logic        stim;
    int          beats;
    int          cyc;
    e = '0;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty actual=0 required>=1");
    end else begin
      e = exp_q.pop_front();
    end
    ecmd  = e[23:22];
    eaddr = e[21:0];
    is_wr = (ecmd == 2'd1);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (sdram_bus.command == 2'd0 && waited < 200);
    total++;
    if (sdram_bus.command !== ecmd)
      begin bad++; $display("FAIL burst_cmd actual=%0d required=%0d", sdram_bus.command, ecmd); end
    total++;
    if (sdram_bus.data_address !== eaddr)
      begin bad++; $display("FAIL burst_addr actual=%06h required=%06h", sdram_bus.data_address, eaddr); end
    beats = 0;
    cyc   = 0;
    while (beats < BL && cyc < 100) begin
      stim = ($urandom_range(0, 3) != 0);
      if (is_wr) sdram_bus.data_write_done = stim;
      else       sdram_bus.data_read_valid = stim;
      display_vsync = (beats == vs_beat);
      #1;
      total++;
      if (write_pop !== (is_wr && stim) || read_push !== (!is_wr && stim)) begin
        bad++;
        $display("FAIL beat_strobe actual pop=%0b push=%0b required pop=%0b push=%0b",
                 write_pop, read_push, is_wr && stim, !is_wr && stim);
      end
      total++;
      if (sdram_bus.command !== ecmd || sdram_bus.data_address !== eaddr) begin
        bad++;
        $display("FAIL burst_hold actual cmd=%0d addr=%06h required cmd=%0d addr=%06h",
                 sdram_bus.command, sdram_bus.data_address, ecmd, eaddr);
      end
      if (stim) begin
        beats++;
        if (is_wr) begin
          if (write_level != 0) write_level = write_level - 1'b1;
        end else begin
          read_used = read_used + 1'b1;
        end
      end
      cyc++;
      @(negedge clk);
    end
    sdram_bus.data_write_done = 1'b0;
    sdram_bus.data_read_valid = 1'b0;
    display_vsync             = 1'b0;
    if (beats < BL) begin
      total++; bad++;
      $display("FAIL burst_timeout actual beats=%0d required=%0d", beats, BL);
    end
    total++;
    if (sdram_bus.command !== 2'd0 || sdram_bus.data_address !== 22'd0) begin
      bad++;
      $display("FAIL burst_end actual cmd=%0d addr=%06h required cmd=0 addr=000000",
               sdram_bus.command, sdram_bus.data_address);
    end
  endtask

  task automatic count_busy(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (sdram_bus.command != 2'd0) n++;
    end
  endtask

  task automatic pulse_frame_start(output int n);
    frame_start = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) frame_start = 1'b0;
      if (frame_dropped === 1'b1) n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    #1;
    total++;
    if (sdram_bus.command !== 2'd0) begin bad++; $display("FAIL rst_command actual=%0d required=0", sdram_bus.command); end
    total++;
    if (sdram_bus.data_address !== 22'd0) begin bad++; $display("FAIL rst_address actual=%06h required=0", sdram_bus.data_address); end
    total++;
    if (write_pop !== 1'b0 || read_push !== 1'b0) begin bad++; $display("FAIL rst_strobes actual=%0b%0b required=00", write_pop, read_push); end
    total++;
    if (frame_dropped !== 1'b0) begin bad++; $display("FAIL rst_dropped actual=%0b required=0", frame_dropped); end
    total++;
    if (read_buffer !== 2'd1) begin bad++; $display("FAIL rst_read_buffer actual=%0d required=1", read_buffer); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int w, n;
    do_reset();
    write_level = 8;
    push_exp(2'd1, 22'h000000);
    run_burst(-1, w);
    count_busy(12, n);
    total++;
    if (n !== 0) begin bad++; $display("FAIL single_write_quiet actual=%0d required=0", n); end
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    write_level = 200;
    read_used   = 0;
    push_exp(2'd1, 22'h000000);
    push_exp(2'd1, 22'h000008);
    push_exp(2'd1, 2 * STRIDE);
    push_exp(2'd1, 2 * STRIDE + 22'd8);
    push_exp(2'd2, STRIDE);
    push_exp(2'd1, 22'h000000);
    push_exp(2'd1, 22'h000008);
    push_exp(2'd1, 2 * STRIDE);
    push_exp(2'd1, 2 * STRIDE + 22'd8);
    push_exp(2'd2, STRIDE + 22'd8);
    for (int i = 0; i < 10; i++) begin
      run_burst(-1, w);
      if (i > 0) begin
        total++;
        if (w !== 1) begin bad++; $display("FAIL idle_gap burst=%0d actual=%0d required=1", i, w); end
      end
    end
    write_level = 0;
    read_used   = 255;
  endtask

  task automatic test_buffer_swap();
    int w;
    do_reset();
    write_level = 16;
    read_used   = 255;
    push_exp(2'd1, 22'h000000);
    push_exp(2'd1, 22'h000008);
    run_burst(-1, w);
    run_burst(-1, w);
    total++;
    if (read_buffer !== 2'd1) begin bad++; $display("FAIL swap_before actual=%0d required=1", read_buffer); end
    display_vsync = 1'b1;
    @(negedge clk);
    display_vsync = 1'b0;
    @(negedge clk);
    total++;
    if (read_buffer !== 2'd0) begin bad++; $display("FAIL swap_after actual=%0d required=0", read_buffer); end
    read_used = 0;
    push_exp(2'd2, 22'h000000);
    run_burst(-1, w);
    read_used   = 255;
    write_level = 8;
    push_exp(2'd1, 2 * STRIDE);
    run_burst(-1, w);
  endtask

  task automatic test_frame_drop();
    int w, n;
    do_reset();
    pulse_frame_start(n);
    total++;
    if (n !== 0) begin bad++; $display("FAIL drop_at_base actual=%0d required=0", n); end
    write_level = 8;
    push_exp(2'd1, 22'h000000);
    run_burst(-1, w);
    pulse_frame_start(n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL drop_pulse actual=%0d required=1", n); end
    write_level = 8;
    push_exp(2'd1, 22'h000000);
    run_burst(-1, w);
  endtask

  task automatic test_vsync_mid_read();
    int w;
    do_reset();
    write_level = 16;
    read_used   = 255;
    push_exp(2'd1, 22'h000000);
    push_exp(2'd1, 22'h000008);
    run_burst(-1, w);
    run_burst(-1, w);
    read_used = 0;
    push_exp(2'd2, STRIDE);
    push_exp(2'd2, 22'h000000);
    run_burst(3, w);
    total++;
    if (read_buffer !== 2'd1) begin bad++; $display("FAIL vsync_mid_hold actual=%0d required=1", read_buffer); end
    run_burst(-1, w);
    read_used = 255;
    total++;
    if (read_buffer !== 2'd0) begin bad++; $display("FAIL vsync_mid_swap actual=%0d required=0", read_buffer); end
  endtask

  task automatic test_fifo_threshold();
    int w, n;
    do_reset();
    write_level = 16;
    read_used   = 255;
    push_exp(2'd1, 22'h000000);
    push_exp(2'd1, 22'h000008);
    run_burst(-1, w);
    run_burst(-1, w);
    read_used = 248;
    count_busy(10, n);
    total++;
    if (n !== 0) begin bad++; $display("FAIL threshold_248 actual=%0d required=0", n); end
    read_used = 247;
    push_exp(2'd2, STRIDE);
    run_burst(-1, w);
    read_used = 255;
  endtask

  task automatic test_reset_mid_burst();
    int waited;
    do_reset();
    write_level = 8;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (sdram_bus.command != 2'd1 && waited < 50);
    sdram_bus.data_write_done = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (sdram_bus.command !== 2'd0 || write_pop !== 1'b0 || sdram_bus.data_address !== 22'd0) begin
      bad++;
      $display("FAIL reset_mid_burst actual cmd=%0d pop=%0b addr=%06h required cmd=0 pop=0 addr=000000",
               sdram_bus.command, write_pop, sdram_bus.data_address);
    end
    sdram_bus.data_write_done = 1'b0;
    write_level = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_buffer_swap();
    test_frame_drop();
    test_vsync_mid_read();
    test_fifo_threshold();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
